// File: rtl/sid_reg_if_pkg.sv
// Register map of the SID window: voice bases/offsets, filter and read-only addresses.
package sid_pkg;
  localparam int SID_VOICE_STRIDE = 7;
  localparam logic [4:0] SID_V1_BASE = 5'h00;
  localparam logic [4:0] SID_V2_BASE = 5'h07;
  localparam logic [4:0] SID_V3_BASE = 5'h0E;

  localparam int SID_OFS_FREQ_LO = 0;
  localparam int SID_OFS_FREQ_HI = 1;
  localparam int SID_OFS_PW_LO   = 2;
  localparam int SID_OFS_PW_HI   = 3;
  localparam int SID_OFS_CONTROL = 4;
  localparam int SID_OFS_ATT_DEC = 5;
  localparam int SID_OFS_SUS_REL = 6;

  localparam logic [4:0] SID_FC_LO    = 5'h15;
  localparam logic [4:0] SID_FC_HI    = 5'h16;
  localparam logic [4:0] SID_RES_FILT = 5'h17;
  localparam logic [4:0] SID_MODE_VOL = 5'h18;
  localparam logic [4:0] SID_POTX     = 5'h19;
  localparam logic [4:0] SID_POTY     = 5'h1A;
  localparam logic [4:0] SID_OSC3     = 5'h1B;
  localparam logic [4:0] SID_ENV3     = 5'h1C;

  function automatic logic [4:0] sid_voice_addr(input int v, input int ofs);
    return 5'(v * SID_VOICE_STRIDE + ofs);
  endfunction
endpackage

// File: rtl/sid_bus_latch.sv
// Fading data-bus latch: holds the last bus value and clears it after BUS_DECAY_TICKS idle ce_1m ticks.
module sid_bus_latch #(
  parameter int BUS_DECAY_TICKS = 2000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ce_1m,
  input  logic       load,
  input  logic [7:0] load_data,
  output logic [7:0] bus_val
);
  localparam int CW = $clog2(BUS_DECAY_TICKS + 1);

  logic [CW-1:0] r_cnt;
  logic [7:0]    r_val;

  // load has priority over an expiry landing on the same tick
  always_ff @(posedge clock) begin
    if (reset) begin
      r_cnt <= '0;
      r_val <= 8'h00;
    end else if (load) begin
      r_val <= load_data;
      r_cnt <= CW'(BUS_DECAY_TICKS);
    end else if (ce_1m && r_cnt != '0) begin
      r_cnt <= r_cnt - CW'(1);
      if (r_cnt == CW'(1)) r_val <= 8'h00;
    end
  end

  assign bus_val = r_val;
endmodule

// File: rtl/sid_reg_if.sv
// SID CPU register interface: decodes bus writes into voice/filter registers and returns read-only values.
// Optional fading bus latch enabled by defining SID_BUS_DECAY_EN.
module sid_reg_if
  import sid_pkg::*;
#(
  parameter int BUS_DECAY_TICKS = 2000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ce_1m,
  input  logic        cs,
  input  logic        we,
  input  logic [4:0]  addr,
  input  logic [7:0]  data_in,
  output logic [7:0]  data_out,
  input  logic [7:0]  pot_x,
  input  logic [7:0]  pot_y,
  input  logic [7:0]  osc3,
  input  logic [7:0]  env3,
  output logic [47:0] freq,
  output logic [35:0] pw,
  output logic [23:0] control,
  output logic [23:0] att_dec,
  output logic [23:0] sus_rel,
  output logic [10:0] fc,
  output logic [7:0]  res_filt,
  output logic [7:0]  mode_vol
);
  logic [47:0] r_freq;
  logic [35:0] r_pw;
  logic [23:0] r_control, r_att_dec, r_sus_rel;
  logic [10:0] r_fc;
  logic [7:0]  r_res_filt, r_mode_vol, r_data_out;

  logic       w_access;
  logic       w_is_ro;
  logic [7:0] w_bus_val;
  logic [7:0] w_rd_data;

  assign w_access = ce_1m & cs;
  assign w_is_ro  = (addr >= SID_POTX) && (addr <= SID_ENV3);

`ifdef SID_BUS_DECAY_EN
  logic       w_load;
  logic [7:0] w_load_data;

  // writes load even at ignored addresses; reads load only what the chip actually drives
  assign w_load      = w_access & (we | w_is_ro);
  assign w_load_data = we ? data_in : w_rd_data;

  sid_bus_latch #(.BUS_DECAY_TICKS(BUS_DECAY_TICKS)) u_bus_latch (
    .clock     (clock),
    .reset     (reset),
    .ce_1m     (ce_1m),
    .load      (w_load),
    .load_data (w_load_data),
    .bus_val   (w_bus_val)
  );
`else
  assign w_bus_val = 8'h00;
`endif

  always_comb begin
    w_rd_data = w_bus_val;
    case (addr)
      SID_POTX: w_rd_data = pot_x;
      SID_POTY: w_rd_data = pot_y;
      SID_OSC3: w_rd_data = osc3;
      SID_ENV3: w_rd_data = env3;
      default:  w_rd_data = w_bus_val;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_freq     <= '0;
      r_pw       <= '0;
      r_control  <= '0;
      r_att_dec  <= '0;
      r_sus_rel  <= '0;
      r_fc       <= '0;
      r_res_filt <= '0;
      r_mode_vol <= '0;
      r_data_out <= '0;
    end else if (w_access) begin
      if (we) begin
        for (int v = 0; v < 3; v++) begin
          if (addr == sid_voice_addr(v, SID_OFS_FREQ_LO)) r_freq[16*v +: 8]     <= data_in;
          if (addr == sid_voice_addr(v, SID_OFS_FREQ_HI)) r_freq[16*v+8 +: 8]   <= data_in;
          if (addr == sid_voice_addr(v, SID_OFS_PW_LO))   r_pw[12*v +: 8]       <= data_in;
          if (addr == sid_voice_addr(v, SID_OFS_PW_HI))   r_pw[12*v+8 +: 4]     <= data_in[3:0];
          if (addr == sid_voice_addr(v, SID_OFS_CONTROL)) r_control[8*v +: 8]   <= data_in;
          if (addr == sid_voice_addr(v, SID_OFS_ATT_DEC)) r_att_dec[8*v +: 8]   <= data_in;
          if (addr == sid_voice_addr(v, SID_OFS_SUS_REL)) r_sus_rel[8*v +: 8]   <= data_in;
        end
        if (addr == SID_FC_LO)    r_fc[2:0]  <= data_in[2:0];
        if (addr == SID_FC_HI)    r_fc[10:3] <= data_in;
        if (addr == SID_RES_FILT) r_res_filt <= data_in;
        if (addr == SID_MODE_VOL) r_mode_vol <= data_in;
      end else begin
        r_data_out <= w_rd_data;
      end
    end
  end

  assign freq     = r_freq;
  assign pw       = r_pw;
  assign control  = r_control;
  assign att_dec  = r_att_dec;
  assign sus_rel  = r_sus_rel;
  assign fc       = r_fc;
  assign res_filt = r_res_filt;
  assign mode_vol = r_mode_vol;
  assign data_out = r_data_out;
endmodule

// File: tb/tb_sid_reg_if.sv
// Directed bench for sid_reg_if: table of register accesses plus hand sequences for gating, decay and reset.
module tb_sid_reg_if;
  logic        clock = 1'b0;
  logic        reset, ce_1m, cs, we;
  logic [4:0]  addr;
  logic [7:0]  data_in, data_out, pot_x, pot_y, osc3, env3;
  logic [47:0] freq;
  logic [35:0] pw;
  logic [23:0] control, att_dec, sus_rel;
  logic [10:0] fc;
  logic [7:0]  res_filt, mode_vol;

  int n_pass = 0;
  int n_tot  = 0;

  localparam int F_ATT = 0, F_SUS = 1, F_CTL = 2, F_PW = 3, F_FC = 4, F_FRQ = 5,
                 F_RES = 6, F_MV = 7, F_DO = 8;

  typedef struct {
    logic        we;
    logic [4:0]  a;
    logic [7:0]  d;
    int          fld;
    logic [47:0] exp;
  } vec_t;

  vec_t vecs[18];

  sid_reg_if #(.BUS_DECAY_TICKS(4)) dut (
    .clock(clock), .reset(reset), .ce_1m(ce_1m), .cs(cs), .we(we), .addr(addr),
    .data_in(data_in), .data_out(data_out), .pot_x(pot_x), .pot_y(pot_y),
    .osc3(osc3), .env3(env3), .freq(freq), .pw(pw), .control(control),
    .att_dec(att_dec), .sus_rel(sus_rel), .fc(fc), .res_filt(res_filt),
    .mode_vol(mode_vol)
  );

  always #5 clock = ~clock;

  function automatic logic [47:0] get_field(input int f);
    case (f)
      F_ATT:   return {24'h0, att_dec};
      F_SUS:   return {24'h0, sus_rel};
      F_CTL:   return {24'h0, control};
      F_PW:    return {12'h0, pw};
      F_FC:    return {37'h0, fc};
      F_FRQ:   return freq;
      F_RES:   return {40'h0, res_filt};
      F_MV:    return {40'h0, mode_vol};
      default: return {40'h0, data_out};
    endcase
  endfunction

  task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // one-clock ce_1m pulse carrying a bus access; outputs sampled 1ns after the edge
  task automatic access(input logic c, input logic w, input logic [4:0] a, input logic [7:0] d);
    @(posedge clock); #1;
    ce_1m = 1'b1; cs = c; we = w; addr = a; data_in = d;
    @(posedge clock); #1;
    ce_1m = 1'b0; cs = 1'b0; we = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{1'b1, 5'h05, 8'h39, F_ATT, 48'h39};
    vecs[1]  = '{1'b1, 5'h06, 8'hA7, F_SUS, 48'hA7};
    vecs[2]  = '{1'b1, 5'h04, 8'h41, F_CTL, 48'h41};
    vecs[3]  = '{1'b1, 5'h0B, 8'hF2, F_CTL, 48'hF241};
    vecs[4]  = '{1'b1, 5'h03, 8'hFF, F_PW,  48'hF00};
    vecs[5]  = '{1'b1, 5'h0A, 8'hAB, F_PW,  48'hB00F00};
    vecs[6]  = '{1'b1, 5'h15, 8'hFF, F_FC,  48'h007};
    vecs[7]  = '{1'b1, 5'h16, 8'h80, F_FC,  48'h407};
    vecs[8]  = '{1'b1, 5'h0E, 8'h34, F_FRQ, 48'h0034_0000_0000};
    vecs[9]  = '{1'b1, 5'h0F, 8'h12, F_FRQ, 48'h1234_0000_0000};
    vecs[10] = '{1'b1, 5'h17, 8'hF1, F_RES, 48'hF1};
    vecs[11] = '{1'b1, 5'h18, 8'h0F, F_MV,  48'h0F};
    vecs[12] = '{1'b0, 5'h19, 8'h00, F_DO,  48'h11};
    vecs[13] = '{1'b0, 5'h1A, 8'h00, F_DO,  48'h22};
    vecs[14] = '{1'b0, 5'h1B, 8'h00, F_DO,  48'h33};
    vecs[15] = '{1'b0, 5'h1C, 8'h00, F_DO,  48'h5D};
    vecs[16] = '{1'b1, 5'h12, 8'hC3, F_DO,  48'h5D};
    vecs[17] = '{1'b1, 5'h1C, 8'h55, F_CTL, 48'hC3F241};

    reset = 1'b1; ce_1m = 1'b0; cs = 1'b0; we = 1'b0; addr = '0; data_in = '0;
    pot_x = 8'h11; pot_y = 8'h22; osc3 = 8'h33; env3 = 8'h5D;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;

    chk("reset_ctl", {24'h0, control}, 48'h0);
    chk("reset_do",  {40'h0, data_out}, 48'h0);

    foreach (vecs[i]) begin
      access(1'b1, vecs[i].we, vecs[i].a, vecs[i].d);
      chk($sformatf("vec%0d", i), get_field(vecs[i].fld), vecs[i].exp);
    end
    chk("ignored_fc",  {37'h0, fc}, 48'h407);
    chk("ignored_frq", freq, 48'h1234_0000_0000);

    // data_out holds once env3 moves without a new read
    env3 = 8'h66;
    repeat (3) @(posedge clock);
    #1 chk("do_hold", {40'h0, data_out}, 48'h5D);

    // cs low, then ce_1m low: neither may write
    access(1'b0, 1'b1, 5'h05, 8'hEE);
    chk("cs_low", {24'h0, att_dec}, 48'h39);
    @(posedge clock); #1;
    cs = 1'b1; we = 1'b1; addr = 5'h05; data_in = 8'hEE;
    @(posedge clock); #1;
    cs = 1'b0; we = 1'b0;
    chk("ce_low", {24'h0, att_dec}, 48'h39);

    // back-to-back ce ticks to the same field: last write wins
    access(1'b1, 1'b1, 5'h01, 8'h77);
    access(1'b1, 1'b1, 5'h01, 8'h88);
    chk("b2b_frq", freq, 48'h1234_0000_8800);

    // bus value readback on a write-only register
    access(1'b1, 1'b1, 5'h00, 8'hAB);
    chk("frq_lo", freq, 48'h1234_0000_88AB);
    access(1'b1, 1'b0, 5'h00, 8'h00);
`ifdef SID_BUS_DECAY_EN
    chk("bus_latch", {40'h0, data_out}, 48'hAB);
    repeat (4) access(1'b0, 1'b0, 5'h00, 8'h00);
    access(1'b1, 1'b0, 5'h00, 8'h00);
    chk("bus_decay", {40'h0, data_out}, 48'h0);
`else
    chk("bus_zero", {40'h0, data_out}, 48'h0);
`endif

    // load data_out, then reset on an access cycle: reset wins
    access(1'b1, 1'b0, 5'h1A, 8'h00);
    chk("pre_reset_do", {40'h0, data_out}, 48'h22);
    @(posedge clock); #1;
    reset = 1'b1; ce_1m = 1'b1; cs = 1'b1; we = 1'b1; addr = 5'h05; data_in = 8'hFF;
    @(posedge clock); #1;
    reset = 1'b0; ce_1m = 1'b0; cs = 1'b0; we = 1'b0;
    chk("rst_freq", freq, 48'h0);
    chk("rst_pw",   {12'h0, pw}, 48'h0);
    chk("rst_ctl",  {24'h0, control}, 48'h0);
    chk("rst_att",  {24'h0, att_dec}, 48'h0);
    chk("rst_sus",  {24'h0, sus_rel}, 48'h0);
    chk("rst_misc", {29'h0, fc, res_filt, mode_vol}, 48'h0);
    chk("rst_do",   {40'h0, data_out}, 48'h0);
    access(1'b1, 1'b0, 5'h00, 8'h00);
    chk("post_rst_rd", {40'h0, data_out}, 48'h0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
